// File: rtl/clk_ce_if.sv
// Control/status bundle between the CPU clock-enable generator and its host.
// The master drives the mode, divisor and step button, and the slave returns the enable and status.
interface clk_ce_if #(
  parameter int unsigned CNT_W = 27
);
  logic [1:0]       mode;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             step_btn;
  logic             ce;
  logic             sq_out;
  logic [CNT_W-1:0] div_active;
  logic             load_err;
  logic [15:0]      ce_count;

  modport master (
    output mode, div_load, div_value, step_btn,
    input  ce, sq_out, div_active, load_err, ce_count
  );

  modport slave (
    input  mode, div_load, div_value, step_btn,
    output ce, sq_out, div_active, load_err, ce_count
  );
endinterface

// File: rtl/clk_ce_gen.sv
// Clock-enable generator for the CPU domain. It supports halt, debounced single-step, divided
// rate and full rate, and it exports a square wave and a pulse counter for the debug display.
module clk_ce_gen #(
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DIV_DEFAULT = 100_000_000,
  parameter int unsigned DB_W        = 20,
  parameter int unsigned DB_CYCLES   = 1_000_000
) (
  input logic     clk_100mhz,
  input logic     reset,
  clk_ce_if.slave bus
);

  typedef enum logic [1:0] {
    ModeHalt = 2'b00,
    ModeStep = 2'b01,
    ModeDiv  = 2'b10,
    ModeFull = 2'b11
  } mode_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic             ce_q, ce_d;
  logic             sq_q, sq_d;
  logic             load_err_q, load_err_d;
  logic [15:0]      ce_count_q, ce_count_d;
  logic             btn_meta_q, btn_meta_d;
  logic             btn_sync_q, btn_sync_d;
  logic             db_level_q, db_level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             step_rise_q, step_rise_d;

  mode_e mode;
  logic  load_ok;
  logic  wrap;

  always_comb begin
    mode    = mode_e'(bus.mode);
    load_ok = bus.div_load && (bus.div_value >= CNT_W'(2));
    wrap    = (mode == ModeDiv) && (cnt_q == div_active_q - CNT_W'(1));

    // A rejected load leaves both the divisor and the count untouched.
    div_active_d = load_ok ? bus.div_value : div_active_q;
    load_err_d   = bus.div_load && !load_ok;

    if (load_ok || (mode != ModeDiv) || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    sq_d = (mode == ModeDiv) && (cnt_q < (div_active_q >> 1));

    btn_meta_d  = bus.step_btn;
    btn_sync_d  = btn_meta_q;
    db_level_d  = db_level_q;
    db_cnt_d    = '0;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        db_level_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    step_rise_d = db_level_d && !db_level_q;

    unique case (mode)
      ModeHalt: ce_d = 1'b0;
      ModeStep: ce_d = step_rise_q;
      ModeDiv:  ce_d = wrap && !load_ok;  // a concurrent load swallows this wrap
      ModeFull: ce_d = 1'b1;
      default:  ce_d = 1'b0;
    endcase

    ce_count_d = ce_count_q + {15'd0, ce_d};
  end

  always_ff @(posedge clk_100mhz) begin
    if (!reset) begin
      cnt_q        <= '0;
      div_active_q <= CNT_W'(DIV_DEFAULT);
      ce_q         <= 1'b0;
      sq_q         <= 1'b0;
      load_err_q   <= 1'b0;
      ce_count_q   <= '0;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      db_level_q   <= 1'b0;
      db_cnt_q     <= '0;
      step_rise_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      ce_q         <= ce_d;
      sq_q         <= sq_d;
      load_err_q   <= load_err_d;
      ce_count_q   <= ce_count_d;
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
      db_level_q   <= db_level_d;
      db_cnt_q     <= db_cnt_d;
      step_rise_q  <= step_rise_d;
    end
  end

  assign bus.ce         = ce_q;
  assign bus.sq_out     = sq_q;
  assign bus.div_active = div_active_q;
  assign bus.load_err   = load_err_q;
  assign bus.ce_count   = ce_count_q;

endmodule

// File: tb/tb_clk_ce_gen.sv
// Directed bench for clk_ce_gen with a divisor of 4 and a debounce of 4 cycles.
// The bench drives and samples 1 ns after each rising edge.
module tb_clk_ce_gen;

  localparam int unsigned CNT_W = 27;

  logic clk_100mhz = 1'b0;
  logic reset      = 1'b0;
  int   n_tests    = 0;
  int   n_fail     = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  clk_ce_if #(.CNT_W(CNT_W)) bus_if ();

  clk_ce_gen #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(4),
    .DB_W       (20),
    .DB_CYCLES  (4)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .reset     (reset),
    .bus       (bus_if.slave)
  );

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] next_mode);
    reset              = 1'b0;
    bus_if.mode        = 2'b00;
    bus_if.div_load    = 1'b0;
    bus_if.div_value   = '0;
    bus_if.step_btn    = 1'b0;
    tick();
    tick();
    reset       = 1'b1;
    bus_if.mode = next_mode;
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    reset = 1'b0;
    tick();
    n_tests++;
    if (bus_if.ce !== 1'b0) begin
      n_fail++; $display("FAIL reset_ce: got %b expected 0", bus_if.ce);
    end
    n_tests++;
    if (bus_if.sq_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_sq: got %b expected 0", bus_if.sq_out);
    end
    n_tests++;
    if (bus_if.load_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_load_err: got %b expected 0", bus_if.load_err);
    end
    n_tests++;
    if (bus_if.ce_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_ce_count: got %0d expected 0", bus_if.ce_count);
    end
    n_tests++;
    if (bus_if.div_active !== CNT_W'(4)) begin
      n_fail++; $display("FAIL reset_div_active: got %0d expected 4", bus_if.div_active);
    end
  endtask

  task automatic test_divided();
    logic exp_ce, exp_sq;
    do_reset(2'b10);
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_ce = (i % 4 == 0);
      exp_sq = ((i - 1) % 4 < 2);
      n_tests++;
      if (bus_if.ce !== exp_ce) begin
        n_fail++; $display("FAIL div_ce cycle %0d: got %b expected %b", i, bus_if.ce, exp_ce);
      end
      n_tests++;
      if (bus_if.sq_out !== exp_sq) begin
        n_fail++; $display("FAIL div_sq cycle %0d: got %b expected %b", i, bus_if.sq_out, exp_sq);
      end
    end
    n_tests++;
    if (bus_if.ce_count !== 16'd5) begin
      n_fail++; $display("FAIL div_ce_count: got %0d expected 5", bus_if.ce_count);
    end
  endtask

  // Continues from test_divided: cnt is 0 here.
  task automatic test_load();
    logic exp_ce;
    tick();
    tick();
    bus_if.div_load  = 1'b1;
    bus_if.div_value = CNT_W'(6);
    tick();
    bus_if.div_load  = 1'b0;
    n_tests++;
    if (bus_if.div_active !== CNT_W'(6)) begin
      n_fail++; $display("FAIL load_div_active: got %0d expected 6", bus_if.div_active);
    end
    n_tests++;
    if (bus_if.load_err !== 1'b0) begin
      n_fail++; $display("FAIL load_no_err: got %b expected 0", bus_if.load_err);
    end
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_ce = (k % 6 == 0);
      n_tests++;
      if (bus_if.ce !== exp_ce) begin
        n_fail++; $display("FAIL load_ce cycle %0d: got %b expected %b", k, bus_if.ce, exp_ce);
      end
    end
    n_tests++;
    if (bus_if.ce_count !== 16'd7) begin
      n_fail++; $display("FAIL load_ce_count: got %0d expected 7", bus_if.ce_count);
    end
  endtask

  // Continues from test_load: divisor 6, cnt is 1 here.
  task automatic test_load_err();
    logic exp_err, exp_ce;
    for (int e = 1; e <= 6; e++) begin
      bus_if.div_load  = (e == 1) || (e == 3);
      bus_if.div_value = (e == 1) ? CNT_W'(1) : CNT_W'(0);
      tick();
      exp_err = (e == 1) || (e == 3);
      exp_ce  = (e == 5);
      n_tests++;
      if (bus_if.load_err !== exp_err) begin
        n_fail++;
        $display("FAIL load_err cycle %0d: got %b expected %b", e, bus_if.load_err, exp_err);
      end
      n_tests++;
      if (bus_if.ce !== exp_ce) begin
        n_fail++; $display("FAIL err_ce cycle %0d: got %b expected %b", e, bus_if.ce, exp_ce);
      end
      n_tests++;
      if (bus_if.div_active !== CNT_W'(6)) begin
        n_fail++;
        $display("FAIL err_div_active cycle %0d: got %0d expected 6", e, bus_if.div_active);
      end
    end
    bus_if.div_load = 1'b0;
    n_tests++;
    if (bus_if.ce_count !== 16'd8) begin
      n_fail++; $display("FAIL err_ce_count: got %0d expected 8", bus_if.ce_count);
    end
  endtask

  task automatic test_step();
    bit glitch [20] = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic exp_ce;
    do_reset(2'b01);
    for (int i = 0; i < 20; i++) begin
      bus_if.step_btn = glitch[i];
      tick();
      n_tests++;
      if (bus_if.ce !== 1'b0) begin
        n_fail++; $display("FAIL step_glitch cycle %0d: got %b expected 0", i, bus_if.ce);
      end
    end
    for (int p = 0; p < 2; p++) begin
      bus_if.step_btn = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        tick();
        exp_ce = (k == 7);
        n_tests++;
        if (bus_if.ce !== exp_ce) begin
          n_fail++;
          $display("FAIL step_press%0d cycle %0d: got %b expected %b", p, k, bus_if.ce, exp_ce);
        end
      end
      bus_if.step_btn = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        n_tests++;
        if (bus_if.ce !== 1'b0) begin
          n_fail++; $display("FAIL step_release%0d cycle %0d: got %b expected 0", p, k, bus_if.ce);
        end
      end
    end
    n_tests++;
    if (bus_if.ce_count !== 16'd2) begin
      n_fail++; $display("FAIL step_ce_count: got %0d expected 2", bus_if.ce_count);
    end
    // A press debounced while halted must not fire once stepping resumes.
    bus_if.mode     = 2'b00;
    bus_if.step_btn = 1'b1;
    repeat (10) tick();
    bus_if.mode = 2'b01;
    repeat (5) tick();
    n_tests++;
    if (bus_if.ce_count !== 16'd2) begin
      n_fail++; $display("FAIL step_halted_press: got %0d expected 2", bus_if.ce_count);
    end
    bus_if.step_btn = 1'b0;
  endtask

  task automatic test_full();
    do_reset(2'b11);
    for (int k = 1; k <= 12; k++) begin
      if (k == 9) bus_if.mode = 2'b00;
      tick();
      n_tests++;
      if (bus_if.ce !== (k <= 8)) begin
        n_fail++; $display("FAIL full_ce cycle %0d: got %b expected %b", k, bus_if.ce, (k <= 8));
      end
      n_tests++;
      if (bus_if.sq_out !== 1'b0) begin
        n_fail++; $display("FAIL full_sq cycle %0d: got %b expected 0", k, bus_if.sq_out);
      end
      n_tests++;
      if (bus_if.ce_count !== 16'((k <= 8) ? k : 8)) begin
        n_fail++;
        $display("FAIL full_ce_count cycle %0d: got %0d expected %0d", k, bus_if.ce_count,
                 (k <= 8) ? k : 8);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2'b10);
    bus_if.div_load  = 1'b1;
    bus_if.div_value = CNT_W'(5);
    tick();
    bus_if.div_load  = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      tick();
      n_tests++;
      if (bus_if.ce !== (k == 6)) begin
        n_fail++; $display("FAIL mid_ce cycle %0d: got %b expected %b", k, bus_if.ce, (k == 6));
      end
    end
    n_tests++;
    if (bus_if.ce_count !== 16'd1 || bus_if.div_active !== CNT_W'(5)) begin
      n_fail++;
      $display("FAIL mid_pre_reset: got count %0d div %0d expected count 1 div 5",
               bus_if.ce_count, bus_if.div_active);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_tests++;
    if (bus_if.ce !== 1'b0 || bus_if.sq_out !== 1'b0 || bus_if.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags: got ce %b sq %b err %b expected 0 0 0",
               bus_if.ce, bus_if.sq_out, bus_if.load_err);
    end
    n_tests++;
    if (bus_if.ce_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", bus_if.ce_count);
    end
    n_tests++;
    if (bus_if.div_active !== CNT_W'(4)) begin
      n_fail++; $display("FAIL mid_reset_div: got %0d expected 4", bus_if.div_active);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++;
      if (bus_if.ce !== (k == 4)) begin
        n_fail++;
        $display("FAIL mid_restart_ce cycle %0d: got %b expected %b", k, bus_if.ce, (k == 4));
      end
    end
  endtask

  task automatic test_count_wrap();
    do_reset(2'b11);
    repeat (65535) tick();
    n_tests++;
    if (bus_if.ce_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_max: got %0h expected ffff", bus_if.ce_count);
    end
    tick();
    n_tests++;
    if (bus_if.ce_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero: got %0h expected 0", bus_if.ce_count);
    end
  endtask

  initial begin
    bus_if.mode      = 2'b00;
    bus_if.div_load  = 1'b0;
    bus_if.div_value = '0;
    bus_if.step_btn  = 1'b0;
    test_reset();
    test_divided();
    test_load();
    test_load_err();
    test_step();
    test_full();
    test_reset_mid();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
